lamp_ramp_ctrl: RTL and testbench

Parametrised, sequential successor to the smart-home lamp-state decoder. It takes a requested number of active lamps and drives a thermometer-coded lamp bank. The bank moves toward the request one lamp at a time at a programmable step rate (soft ramp), or jumps directly when instant mode is requested. It sits between the light-sensor/occupancy logic that computes the lamp count and the physical lamp outputs.

---
 rtl/lamp_pkg.sv | 17 +
 rtl/lamp_ramp_ctrl_if.sv | 27 ++
 rtl/thermo_decode.sv | 14 +
 rtl/lamp_ramp_ctrl.sv | 112 +++++++++++
 tb/tb_lamp_ramp_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/lamp_pkg.sv
// Shared lighting types and defaults: ramp FSM states, bank defaults, count clamp helper.
package lamp_pkg;

  localparam int DEFAULT_NUM_LAMPS   = 16;
  localparam int DEFAULT_STEP_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

  function automatic int clamp_count(input int value, input int max_count);
    return (value > max_count) ? max_count : value;
  endfunction

endpackage

// File: rtl/lamp_ramp_ctrl_if.sv
// Request/status bundle between the lamp-count source (master) and the ramp controller (slave).
interface lamp_ramp_ctrl_if
  import lamp_pkg::*;
#(
  parameter int NUM_LAMPS = DEFAULT_NUM_LAMPS,
  parameter int CNT_W     = $clog2(NUM_LAMPS + 1)
);

  logic                 target_valid;
  logic [CNT_W-1:0]     target;
  logic                 instant;
  logic [NUM_LAMPS-1:0] lights_state;
  logic [CNT_W-1:0]     active_count;
  logic                 busy;
  logic                 done;

  modport master (
    output target_valid, target, instant,
    input  lights_state, active_count, busy, done
  );

  modport slave (
    input  target_valid, target, instant,
    output lights_state, active_count, busy, done
  );

endinterface

// File: rtl/thermo_decode.sv
// Count to thermometer code: bit i is set iff i_count > i. Purely combinational.
module thermo_decode #(
  parameter int N  = 16,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [CW-1:0] i_count,
  output logic [N-1:0]  o_therm
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign o_therm[i] = (i_count > CW'(i));
  end

endmodule

// File: rtl/lamp_ramp_ctrl.sv
// Soft-ramp lamp bank: moves active_count one lamp per STEP_CYCLES toward the latest request,
// or jumps on instant requests; a new request always replaces the ramp in progress.
module lamp_ramp_ctrl
  import lamp_pkg::*;
#(
  parameter int NUM_LAMPS   = DEFAULT_NUM_LAMPS,
  parameter int STEP_CYCLES = DEFAULT_STEP_CYCLES
) (
  input logic             clk,
  input logic             rst,
  lamp_ramp_ctrl_if.slave bus
);

  localparam int                 CNT_W     = $clog2(NUM_LAMPS + 1);
  localparam int                 SC_W      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SC_W-1:0]    STEP_LAST = SC_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(NUM_LAMPS);

  ramp_state_t      r_state, w_state;
  logic [SC_W-1:0]  r_step, w_step;
  logic [CNT_W-1:0] r_tgt, w_tgt;
  logic [CNT_W-1:0] r_active, w_active;
  logic             r_done, w_done;

  logic [CNT_W-1:0]     w_clamped;
  logic                 w_step_edge;
  logic [NUM_LAMPS-1:0] w_lights;

  assign w_clamped   = CNT_W'(clamp_count(int'(bus.target), NUM_LAMPS));
  assign w_step_edge = (r_step == STEP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_step   <= '0;
      r_tgt    <= '0;
      r_active <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_step   <= w_step;
      r_tgt    <= w_tgt;
      r_active <= w_active;
      r_done   <= w_done;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_step   = r_step;
    w_tgt    = r_tgt;
    w_active = r_active;
    w_done   = 1'b0;

    // A request takes priority over any step due on the same edge.
    if (bus.target_valid) begin
      w_tgt  = w_clamped;
      w_step = '0;
      if (bus.instant) begin
        w_active = w_clamped;
        w_state  = IDLE;
        w_done   = 1'b1;
      end else if (w_clamped > r_active) begin
        w_state = RAMP_UP;
      end else if (w_clamped < r_active) begin
        w_state = RAMP_DOWN;
      end else begin
        w_state = IDLE;
        w_done  = 1'b1;
      end
    end else begin
      case (r_state)
        RAMP_UP: begin
          if (!w_step_edge) begin
            w_step = r_step + SC_W'(1);
          end else begin
            w_step = '0;
            if (r_active < MAX_CNT) w_active = r_active + CNT_W'(1);
            if (w_active >= r_tgt) begin
              w_state = IDLE;
              w_done  = 1'b1;
            end
          end
        end
        RAMP_DOWN: begin
          if (!w_step_edge) begin
            w_step = r_step + SC_W'(1);
          end else begin
            w_step = '0;
            if (r_active != '0) w_active = r_active - CNT_W'(1);
            if (w_active <= r_tgt) begin
              w_state = IDLE;
              w_done  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  thermo_decode #(.N(NUM_LAMPS), .CW(CNT_W)) u_thermo (
    .i_count (r_active),
    .o_therm (w_lights)
  );

  assign bus.lights_state = w_lights;
  assign bus.active_count = r_active;
  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = r_done;

endmodule

// File: tb/tb_lamp_ramp_ctrl.sv
// Two lamp banks (16 lamps/4-cycle step, 8 lamps/1-cycle step) driven in lockstep and checked
// every cycle against a closed-form ramp model: count(k) = base +/- min(dist, (k - t0) / step).
module tb_lamp_ramp_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lamp_ramp_ctrl_if #(.NUM_LAMPS(16)) if0 ();
  lamp_ramp_ctrl_if #(.NUM_LAMPS(8))  if1 ();

  lamp_ramp_ctrl #(.NUM_LAMPS(16), .STEP_CYCLES(4)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  lamp_ramp_ctrl #(.NUM_LAMPS(8),  .STEP_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_cmp = 0;
  int n_err = 0;
  int k     = 0;

  int NL[2] = '{16, 8};
  int SC[2] = '{4, 1};

  int m_base[2];
  int m_tgt[2];
  int m_t0[2];
  bit m_live[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, k);
    end
  endtask

  function automatic int m_dist(input int d);
    return (m_tgt[d] >= m_base[d]) ? (m_tgt[d] - m_base[d]) : (m_base[d] - m_tgt[d]);
  endfunction

  function automatic int m_count(input int d, input int at);
    int steps;
    steps = (at - m_t0[d]) / SC[d];
    if (steps > m_dist(d)) steps = m_dist(d);
    return (m_tgt[d] >= m_base[d]) ? (m_base[d] + steps) : (m_base[d] - steps);
  endfunction

  function automatic bit m_busy(input int d);
    return (k - m_t0[d]) < m_dist(d) * SC[d];
  endfunction

  function automatic bit m_done(input int d);
    return m_live[d] && ((k - m_t0[d]) == m_dist(d) * SC[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_base[d] = 0;
      m_tgt[d]  = 0;
      m_t0[d]   = k;
      m_live[d] = 1'b0;
    end
  endtask

  task automatic accept(input int d, input int tg, input bit inst);
    int pre;
    int c;
    pre       = m_count(d, k - 1);
    c         = (tg > NL[d]) ? NL[d] : tg;
    m_base[d] = inst ? c : pre;
    m_tgt[d]  = c;
    m_t0[d]   = k;
    m_live[d] = 1'b1;
  endtask

  task automatic check_dut(input int d);
    int c;
    c = m_count(d, k);
    if (d == 0) begin
      check_val("d0_count",  32'(if0.active_count), 32'(c));
      check_val("d0_lights", 32'(if0.lights_state), 32'((1 << c) - 1));
      check_val("d0_busy",   32'(if0.busy),         32'(m_busy(0)));
      check_val("d0_done",   32'(if0.done),         32'(m_done(0)));
    end else begin
      check_val("d1_count",  32'(if1.active_count), 32'(c));
      check_val("d1_lights", 32'(if1.lights_state), 32'((1 << c) - 1));
      check_val("d1_busy",   32'(if1.busy),         32'(m_busy(1)));
      check_val("d1_done",   32'(if1.done),         32'(m_done(1)));
    end
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge after checking.
  task automatic cycle(input bit v0, input int tg0, input bit i0,
                       input bit v1, input int tg1, input bit i1);
    if0.target_valid = v0;
    if0.target       = 5'(tg0);
    if0.instant      = i0;
    if1.target_valid = v1;
    if1.target       = 4'(tg1);
    if1.instant      = i1;
    @(posedge clk);
    k++;
    if (v0) accept(0, tg0, i0);
    if (v1) accept(1, tg1, i1);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    if0.target_valid = 1'b0;
    if1.target_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_val("rst_async_lights0", 32'(if0.lights_state), 32'd0);
    check_val("rst_async_lights1", 32'(if1.lights_state), 32'd0);
    check_val("rst_async_busy0",   32'(if0.busy),         32'd0);
    check_val("rst_async_done0",   32'(if0.done),         32'd0);
    model_reset();
    @(posedge clk);
    k++;
    @(negedge clk);
    rst = 1'b0;
    check_dut(0);
    check_dut(1);
  endtask

  initial begin
    if0.target_valid = 1'b0; if0.target = '0; if0.instant = 1'b0;
    if1.target_valid = 1'b0; if1.target = '0; if1.instant = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Ramp up 0 -> 5 at 4 cycles/lamp.
    cycle(1'b1, 5, 1'b0, 1'b0, 0, 1'b0);
    idle(20);
    check_val("up5_lights", 32'(if0.lights_state), 32'h001F);
    check_val("up5_done",   32'(if0.done),         32'd1);
    check_val("up5_busy",   32'(if0.busy),         32'd0);
    idle(2);

    // Instant jump with clamp 20 -> 16.
    cycle(1'b1, 20, 1'b1, 1'b0, 0, 1'b0);
    check_val("inst_count",  32'(if0.active_count), 32'd16);
    check_val("inst_lights", 32'(if0.lights_state), 32'hFFFF);
    check_val("inst_done",   32'(if0.done),         32'd1);
    idle(1);
    check_val("inst_done_low", 32'(if0.done), 32'd0);

    // Ramp down 16 -> 12.
    cycle(1'b1, 12, 1'b0, 1'b0, 0, 1'b0);
    idle(16);
    check_val("dn12_lights", 32'(if0.lights_state), 32'h0FFF);
    check_val("dn12_done",   32'(if0.done),         32'd1);
    idle(2);

    // Reversal at count 4 while ramping 0 -> 10.
    cycle(1'b1, 0, 1'b1, 1'b0, 0, 1'b0);
    idle(1);
    cycle(1'b1, 10, 1'b0, 1'b0, 0, 1'b0);
    idle(16);
    check_val("rev_at4", 32'(if0.active_count), 32'd4);
    cycle(1'b1, 2, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    check_val("rev_at3", 32'(if0.active_count), 32'd3);
    idle(4);
    check_val("rev_at2",   32'(if0.active_count), 32'd2);
    check_val("rev_done",  32'(if0.done),         32'd1);
    idle(3);
    check_val("rev_hold2", 32'(if0.active_count), 32'd2);

    // Equal target, then reset in mid-ramp.
    cycle(1'b1, 2, 1'b0, 1'b0, 0, 1'b0);
    check_val("eq_done", 32'(if0.done), 32'd1);
    check_val("eq_busy", 32'(if0.busy), 32'd0);
    cycle(1'b1, 15, 1'b0, 1'b0, 0, 1'b0);
    idle(6);
    do_reset();
    idle(3);

    // Single-cycle step bank: 0 -> 8.
    cycle(1'b0, 0, 1'b0, 1'b1, 8, 1'b0);
    idle(8);
    check_val("fast8_lights", 32'(if1.lights_state), 32'h00FF);
    check_val("fast8_done",   32'(if1.done),         32'd1);
    idle(2);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) == 0, int'($urandom_range(0, 31)), $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0, int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
